// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, long-latency results queue and drain into idle slots.
// Optional macro WB_ARB_PERF_EN adds saturating stall/squash performance counters.
module wb_write_arbiter #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        w_regs_we,
    output logic [4:0]  w_regs_addr,
    output logic [31:0] w_regs_data,
    output logic        wb_stall,
    output logic        lu_pending
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_squash_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [AW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DEPTH-1:0] vld_q, vld_d, sq_mask;
    logic [SW-1:0]    starve_q, starve_d;
    logic             stall_q, stall_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic commit_c, empty_c, full_c, head_live_c, head_wr_c, pop_c;
    logic push_acc_c, push_drop_c, push_c;

    // Arbitration, squash and FIFO bookkeeping
    always_comb begin
        commit_c    = pipe_we & (pipe_rd != 5'd0) & ~stall_q;
        empty_c     = (cnt_q == CW'(0));
        full_c      = (cnt_q == CW'(DEPTH));
        lu_ready    = ~full_c;
        lu_pending  = |vld_q;
        wb_stall    = stall_q;

        head_live_c = ~empty_c & vld_q[rptr_q] & ~(commit_c & (rd_q[rptr_q] == pipe_rd));
        head_wr_c   = ~empty_c & ~commit_c & vld_q[rptr_q];
        pop_c       = ~empty_c & ~(commit_c & head_live_c);

        push_acc_c  = lu_valid & lu_ready;
        push_drop_c = push_acc_c & commit_c & (lu_rd == pipe_rd);
        push_c      = push_acc_c & (lu_rd != 5'd0) & ~push_drop_c;

        w_regs_we   = 1'b0;
        w_regs_addr = 5'd0;
        w_regs_data = 32'd0;
        if (commit_c) begin
            w_regs_we   = 1'b1;
            w_regs_addr = pipe_rd;
            w_regs_data = pipe_data;
        end else if (head_wr_c) begin
            w_regs_we   = 1'b1;
            w_regs_addr = rd_q[rptr_q];
            w_regs_data = data_q[rptr_q];
        end

        for (int unsigned i = 0; i < DEPTH; i++) begin
            sq_mask[i] = commit_c & vld_q[i] & (rd_q[i] == pipe_rd);
        end
        vld_d  = vld_q & ~sq_mask;
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        if (pop_c) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + AW'(1);
        end
        if (push_c) begin
            vld_d[wptr_q] = 1'b1;
            wptr_d        = wptr_q + AW'(1);
        end

        unique case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // A blocked valid head counts toward a one-cycle forced drain
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (empty_c || pop_c) begin
            starve_d = '0;
        end else if (starve_q == SW'(STARVE_MAX - 1)) begin
            starve_d = '0;
            stall_d  = 1'b1;
        end else begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            cnt_q    <= '0;
            vld_q    <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // Payload storage needs no reset; valid bits gate every use
    always_ff @(posedge clk) begin
        if (push_c) begin
            rd_q[wptr_q]   <= lu_rd;
            data_q[wptr_q] <= lu_data;
        end
    end

`ifdef WB_ARB_PERF_EN
    localparam int unsigned QW = CW + 1;
    logic [QW-1:0] sq_cnt_c;
    logic [32:0]   sq_sum_c;

    always_comb begin
        sq_cnt_c = QW'(push_drop_c);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sq_cnt_c = sq_cnt_c + QW'(sq_mask[i]);
        end
        sq_sum_c = {1'b0, perf_squash_cnt} + 33'(sq_cnt_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt  <= '0;
            perf_squash_cnt <= '0;
        end else begin
            if (stall_q && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            perf_squash_cnt <= sq_sum_c[32] ? '1 : sq_sum_c[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus randomized traffic vs. a queue model.
module tb_wb_write_arbiter;

    localparam int DEPTH = 2;
    localparam int SM    = 8;

    logic        clk, rst;
    logic        pipe_we, lu_valid, lu_ready, w_regs_we, wb_stall, lu_pending;
    logic [4:0]  pipe_rd, lu_rd, w_regs_addr;
    logic [31:0] pipe_data, lu_data, w_regs_data;
`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_stall_cnt, perf_squash_cnt;
`endif

    wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .w_regs_we(w_regs_we), .w_regs_addr(w_regs_addr), .w_regs_data(w_regs_data),
        .wb_stall(wb_stall), .lu_pending(lu_pending)
`ifdef WB_ARB_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_squash_cnt(perf_squash_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
        bit          v;
    } ent_t;

    ent_t        q[$];
    int          starve_m;
    bit          stall_m;
    int unsigned perf_stall_m, perf_sq_m;
    int          checks, failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit we, input logic [4:0] rd, input logic [31:0] pd,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        pipe_we = we; pipe_rd = rd; pipe_data = pd;
        lu_valid = lv; lu_rd = lrd; lu_data = ld;
    endtask

    // One clock cycle: check outputs against the model, then advance the model
    task automatic step(input bit we, input logic [4:0] rd, input logic [31:0] pd,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        bit commit, ready, pending, popped, was_empty, nstall;
        bit ewe;
        logic [4:0] eaddr;
        logic [31:0] edata;
        int sq;
        drive(we, rd, pd, lv, lrd, ld);
        #4;
        commit  = we && (rd != 0) && !stall_m;
        ready   = (q.size() < DEPTH);
        pending = 0;
        foreach (q[i]) if (q[i].v) pending = 1;
        ewe = 0; eaddr = 0; edata = 0;
        if (commit) begin
            ewe = 1; eaddr = rd; edata = pd;
        end else if (q.size() > 0 && q[0].v) begin
            ewe = 1; eaddr = q[0].rd; edata = q[0].d;
        end
        chk("we", 32'(w_regs_we), 32'(ewe));
        chk("addr", 32'(w_regs_addr), 32'(eaddr));
        chk("data", w_regs_data, edata);
        chk("lu_ready", 32'(lu_ready), 32'(ready));
        chk("lu_pending", 32'(lu_pending), 32'(pending));
        chk("wb_stall", 32'(wb_stall), 32'(stall_m));
`ifdef WB_ARB_PERF_EN
        chk("perf_stall", perf_stall_cnt, perf_stall_m);
        chk("perf_squash", perf_squash_cnt, perf_sq_m);
`endif
        sq = 0;
        if (commit) begin
            foreach (q[i]) if (q[i].v && q[i].rd == rd) begin q[i].v = 0; sq++; end
        end
        was_empty = (q.size() == 0);
        popped = 0;
        if (!was_empty && !(commit && q[0].v)) begin
            void'(q.pop_front());
            popped = 1;
        end
        if (lv && ready && lrd != 0) begin
            if (commit && lrd == rd) sq++;
            else q.push_back('{rd: lrd, d: ld, v: 1'b1});
        end
        nstall = 0;
        if (was_empty || popped) starve_m = 0;
        else begin
            starve_m++;
            if (starve_m == SM) begin nstall = 1; starve_m = 0; end
        end
        if (stall_m) perf_stall_m++;
        perf_sq_m += sq;
        stall_m = nstall;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_peek();
        drive(0, 0, 0, 0, 0, 0);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("rst_pending", 32'(lu_pending), 32'd0);
        chk("rst_ready", 32'(lu_ready), 32'd1);
        chk("rst_stall", 32'(wb_stall), 32'd0);
        chk("rst_we", 32'(w_regs_we), 32'd0);
        chk("rst_addr", 32'(w_regs_addr), 32'd0);
        chk("rst_data", w_regs_data, 32'd0);
        q.delete();
        starve_m = 0; stall_m = 0; perf_stall_m = 0; perf_sq_m = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        do_reset();

        // Idle drain
        step(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        idle_peek();
        chk("drain_we", 32'(w_regs_we), 32'd1);
        chk("drain_addr", 32'(w_regs_addr), 32'd5);
        chk("drain_data", w_regs_data, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0);
        chk("drain_pending", 32'(lu_pending), 32'd0);

        // Pipeline priority then starvation on rd 7
        step(1, 5'd3, 32'h11, 1, 5'd7, 32'h22);
        for (int i = 1; i <= SM; i++) begin
            if (i == SM) chk("stall_early", 32'(wb_stall), 32'd0);
            step(1, 5'd3, 32'h11, 0, 0, 0);
        end
        chk("stall_hi", 32'(wb_stall), 32'd1);
        #1;
        chk("stall_addr", 32'(w_regs_addr), 32'd7);
        chk("stall_data", w_regs_data, 32'h22);
        step(1, 5'd3, 32'h11, 0, 0, 0);
        chk("stall_lo", 32'(wb_stall), 32'd0);
        step(1, 5'd3, 32'h11, 0, 0, 0);

        // WAW squash on rd 9
        step(1, 5'd3, 32'h11, 1, 5'd9, 32'hAA);
        step(1, 5'd9, 32'hBB, 0, 0, 0);
        idle_peek();
        chk("squash_pending", 32'(lu_pending), 32'd0);
        chk("squash_we", 32'(w_regs_we), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // Full FIFO, pop while full, same-cycle dropped push
        step(1, 5'd3, 32'h11, 1, 5'd10, 32'hA0);
        step(1, 5'd3, 32'h11, 1, 5'd11, 32'hA1);
        chk("full_ready", 32'(lu_ready), 32'd0);
        step(0, 0, 0, 1, 5'd12, 32'hA2);
        chk("ready_back", 32'(lu_ready), 32'd1);
        step(1, 5'd4, 32'h44, 1, 5'd4, 32'h55);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // x0 pipe write lets FIFO drain
        step(1, 5'd0, 32'h99, 1, 5'd13, 32'hCC);
        step(1, 5'd0, 32'h99, 0, 0, 0);
        step(1, 5'd0, 32'h99, 0, 0, 0);

        // Reset with two entries buffered
        step(1, 5'd3, 32'h11, 1, 5'd14, 32'hE0);
        step(1, 5'd3, 32'h11, 1, 5'd15, 32'hE1);
        chk("pre_rst_pending", 32'(lu_pending), 32'd1);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

        // Randomized traffic with a narrow register range to force collisions
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
